// File: rtl/tlb_pkg.sv
// tlb_pkg: shared op codes, INVTLB sub-ops and tag field widths for the TLB tag array.
package tlb_pkg;
    localparam int ASID_W = 8;
    localparam int VPN2_W = 19;
    localparam logic [1:0] TLB_OP_WR   = 2'd0;
    localparam logic [1:0] TLB_OP_FILL = 2'd1;
    localparam logic [1:0] TLB_OP_INV  = 2'd2;
    localparam logic [1:0] TLB_OP_NOP  = 2'd3;
    localparam logic [2:0] INV_ALL0          = 3'd0;
    localparam logic [2:0] INV_ALL1          = 3'd1;
    localparam logic [2:0] INV_G             = 3'd2;
    localparam logic [2:0] INV_NG            = 3'd3;
    localparam logic [2:0] INV_NG_ASID       = 3'd4;
    localparam logic [2:0] INV_NG_ASID_VPN   = 3'd5;
    localparam logic [2:0] INV_G_OR_ASID_VPN = 3'd6;
    localparam logic [2:0] INV_NONE          = 3'd7;
endpackage

// File: rtl/tlb_inv_match.sv
// tlb_inv_match: decides whether one entry is hit by an INVTLB sub-op.
module tlb_inv_match
    import tlb_pkg::*;
(
    input  logic              g,
    input  logic [ASID_W-1:0] asid,
    input  logic [VPN2_W-1:0] vpn2,
    input  logic [2:0]        inv_op,
    input  logic [ASID_W-1:0] a,
    input  logic [VPN2_W-1:0] v,
    output logic              hit
);
    logic asid_eq;
    logic vpn_eq;
    always_comb begin
        asid_eq = asid == a;
        vpn_eq  = vpn2 == v;
        hit = (inv_op == INV_ALL0 || inv_op == INV_ALL1) ? 1'b1
            : inv_op == INV_G             ? g
            : inv_op == INV_NG            ? !g
            : inv_op == INV_NG_ASID       ? !g && asid_eq
            : inv_op == INV_NG_ASID_VPN   ? !g && asid_eq && vpn_eq
            : inv_op == INV_G_OR_ASID_VPN ? (g || asid_eq) && vpn_eq
            : 1'b0;
    end
endmodule

// File: rtl/tlb_entry_writer.sv
// tlb_entry_writer: TLB tag storage with indexed/round-robin writes and an
// INVTLB walk that examines one entry per cycle.
module tlb_entry_writer
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    localparam int IDXW = $clog2(TLBNUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [2:0]               inv_op,
    input  logic [IDXW-1:0]          req_index,
    input  logic                     req_e,
    input  logic                     req_g,
    input  logic [ASID_W-1:0]        req_asid,
    input  logic [VPN2_W-1:0]        req_vpn2,
    output logic                     done,
    output logic [IDXW-1:0]          fill_index,
    output logic [TLBNUM-1:0]        all_e,
    output logic [TLBNUM-1:0]        all_g,
    output logic [TLBNUM*ASID_W-1:0] all_asid,
    output logic [TLBNUM*VPN2_W-1:0] all_vpn2
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WALK = 1'b1;
    localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

    logic [TLBNUM-1:0]              e_q, e_d, g_q, g_d;
    logic [TLBNUM-1:0][ASID_W-1:0]  asid_q, asid_d;
    logic [TLBNUM-1:0][VPN2_W-1:0]  vpn2_q, vpn2_d;
    logic [0:0]                     state_q, state_d;
    logic [IDXW-1:0]                k_q, k_d, fill_q, fill_d;
    logic [2:0]                     inv_op_q, inv_op_d;
    logic [ASID_W-1:0]              a_q, a_d;
    logic [VPN2_W-1:0]              v_q, v_d;
    logic                           done_q, done_d;
    logic                           accept, hit;
    logic [IDXW-1:0]                wr_idx;

    assign req_ready  = state_q == S_IDLE;
    assign accept     = req_valid && req_ready;
    assign wr_idx     = req_op == TLB_OP_FILL ? fill_q : req_index;
    assign done       = done_q;
    assign fill_index = fill_q;
    assign all_e      = e_q;
    assign all_g      = g_q;
    assign all_asid   = asid_q;
    assign all_vpn2   = vpn2_q;

    tlb_inv_match u_match (
        .g      (g_q[k_q]),
        .asid   (asid_q[k_q]),
        .vpn2   (vpn2_q[k_q]),
        .inv_op (inv_op_q),
        .a      (a_q),
        .v      (v_q),
        .hit    (hit)
    );

    always_comb begin
        e_d      = e_q;
        g_d      = g_q;
        asid_d   = asid_q;
        vpn2_d   = vpn2_q;
        state_d  = state_q;
        k_d      = k_q;
        fill_d   = fill_q;
        inv_op_d = inv_op_q;
        a_d      = a_q;
        v_d      = v_q;
        done_d   = 1'b0;
        if (accept) begin
            done_d = req_op != TLB_OP_INV;
            if (req_op == TLB_OP_WR || req_op == TLB_OP_FILL) begin
                e_d[wr_idx]    = req_e;
                g_d[wr_idx]    = req_g;
                asid_d[wr_idx] = req_asid;
                vpn2_d[wr_idx] = req_vpn2;
            end
            if (req_op == TLB_OP_FILL) fill_d = fill_q + IDXW'(1);
            if (req_op == TLB_OP_INV) begin
                state_d  = S_WALK;
                k_d      = '0;
                inv_op_d = inv_op;
                a_d      = req_asid;
                v_d      = req_vpn2;
            end
        end
        // Only E is cleared by the walk; the rest of the tag stays for debug/refill.
        if (state_q == S_WALK) begin
            if (hit) e_d[k_q] = 1'b0;
            k_d = k_q + IDXW'(1);
            if (k_q == LAST) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q      <= '0;
            g_q      <= '0;
            asid_q   <= '0;
            vpn2_q   <= '0;
            state_q  <= S_IDLE;
            k_q      <= '0;
            fill_q   <= '0;
            inv_op_q <= '0;
            a_q      <= '0;
            v_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            e_q      <= e_d;
            g_q      <= g_d;
            asid_q   <= asid_d;
            vpn2_q   <= vpn2_d;
            state_q  <= state_d;
            k_q      <= k_d;
            fill_q   <= fill_d;
            inv_op_q <= inv_op_d;
            a_q      <= a_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_tlb_entry_writer.sv
// tb_tlb_entry_writer: directed checks of writes, fills and INVTLB walks.
module tb_tlb_entry_writer;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [2:0]    inv_op = '0;
    logic [3:0]    req_index = '0;
    logic          req_e = 1'b0;
    logic          req_g = 1'b0;
    logic [7:0]    req_asid = '0;
    logic [18:0]   req_vpn2 = '0;
    logic          done;
    logic [3:0]    fill_index;
    logic [15:0]   all_e, all_g;
    logic [127:0]  all_asid;
    logic [303:0]  all_vpn2;
    int n_chk = 0;
    int n_err = 0;
    int cyc, rl, pulses;

    tlb_entry_writer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .inv_op(inv_op), .req_index(req_index), .req_e(req_e),
        .req_g(req_g), .req_asid(req_asid), .req_vpn2(req_vpn2), .done(done),
        .fill_index(fill_index), .all_e(all_e), .all_g(all_g),
        .all_asid(all_asid), .all_vpn2(all_vpn2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] iop, input logic [3:0] idx,
                         input logic e, input logic g, input logic [7:0] asid, input logic [18:0] vpn2);
        req_op = op; inv_op = iop; req_index = idx;
        req_e = e; req_g = g; req_asid = asid; req_vpn2 = vpn2;
        req_valid = 1'b1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] iop, input logic [3:0] idx,
                         input logic e, input logic g, input logic [7:0] asid, input logic [18:0] vpn2);
        drive(op, iop, idx, e, g, asid, vpn2);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int c, output int r);
        c = 0;
        r = 0;
        while (!done && c < max) begin
            if (!req_ready) r++;
            @(posedge clk);
            #1 c++;
        end
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        #2;
        chk("rst_e", 64'(all_e), 64'h0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        do_reset();
        chk("rst_fill", 64'(fill_index), 64'd0);
        chk("rst_asid", 64'(|all_asid), 64'd0);

        issue(2'd0, 3'd0, 4'd3, 1'b1, 1'b0, 8'h12, 19'h1ABCD);
        chk("wr_done", 64'(done), 64'd1);
        chk("wr_e", 64'(all_e), 64'h0008);
        chk("wr_asid", 64'(all_asid[31:24]), 64'h12);
        chk("wr_vpn2", 64'(all_vpn2[75:57]), 64'h1ABCD);
        chk("wr_g", 64'(all_g), 64'h0);
        @(posedge clk);
        #1 chk("wr_done_off", 64'(done), 64'd0);
        issue(2'd3, 3'd0, 4'd5, 1'b1, 1'b1, 8'h77, 19'h7);
        chk("nop_done", 64'(done), 64'd1);
        chk("nop_e", 64'(all_e), 64'h0008);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            chk("fill_idx", 64'(fill_index), 64'(i % 16));
            issue(2'd1, 3'd0, 4'd9, 1'b1, 1'b0, 8'(i), 19'(i));
            chk("fill_done", 64'(done), 64'd1);
        end
        chk("fill_wrap", 64'(fill_index), 64'd1);
        chk("fill_e", 64'(all_e), 64'hFFFF);
        chk("fill_asid0", 64'(all_asid[7:0]), 64'd16);
        chk("fill_asid1", 64'(all_asid[15:8]), 64'd1);
        chk("fill_asid15", 64'(all_asid[127:120]), 64'd15);

        do_reset();
        for (int i = 0; i < 16; i++) issue(2'd1, 3'd0, 4'd0, 1'b1, ~i[0], 8'd5, 19'(i));
        chk("ng_g", 64'(all_g), 64'h5555);
        issue(2'd2, 3'd3, 4'd0, 1'b0, 1'b0, 8'd0, 19'd0);
        chk("ng_ready0", 64'(req_ready), 64'd0);
        chk("ng_done0", 64'(done), 64'd0);
        drive(2'd0, 3'd0, 4'd1, 1'b1, 1'b0, 8'hAA, 19'h0);
        wait_done(40, cyc, rl);
        chk("ng_cycles", 64'(cyc), 64'd16);
        chk("ng_ready_low", 64'(rl), 64'd16);
        chk("ng_e", 64'(all_e), 64'h5555);
        chk("ng_ready_at_done", 64'(req_ready), 64'd1);
        chk("ng_held_not_taken", 64'(all_asid[15:8]), 64'd5);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("held_done", 64'(done), 64'd1);
        chk("held_e", 64'(all_e), 64'h5557);
        chk("held_asid", 64'(all_asid[15:8]), 64'hAA);

        do_reset();
        issue(2'd0, 3'd0, 4'd2, 1'b1, 1'b0, 8'd7, 19'h100);
        issue(2'd0, 3'd0, 4'd4, 1'b1, 1'b1, 8'd0, 19'h100);
        issue(2'd0, 3'd0, 4'd6, 1'b1, 1'b0, 8'd8, 19'h100);
        issue(2'd0, 3'd0, 4'd8, 1'b1, 1'b0, 8'd7, 19'h200);
        chk("op6_pre", 64'(all_e), 64'h0154);
        issue(2'd2, 3'd6, 4'd0, 1'b0, 1'b0, 8'd7, 19'h100);
        wait_done(40, cyc, rl);
        chk("op6_e", 64'(all_e), 64'h0140);
        chk("op6_vpn2_kept", 64'(all_vpn2[56:38]), 64'h100);

        do_reset();
        issue(2'd0, 3'd0, 4'd0, 1'b1, 1'b1, 8'd1, 19'd1);
        issue(2'd0, 3'd0, 4'd1, 1'b1, 1'b0, 8'd1, 19'd1);
        issue(2'd0, 3'd0, 4'd2, 1'b1, 1'b0, 8'd1, 19'd2);
        issue(2'd0, 3'd0, 4'd3, 1'b1, 1'b0, 8'd2, 19'd1);
        issue(2'd2, 3'd5, 4'd0, 1'b0, 1'b0, 8'd1, 19'd1);
        wait_done(40, cyc, rl);
        chk("op5_e", 64'(all_e), 64'hD);
        issue(2'd2, 3'd4, 4'd0, 1'b0, 1'b0, 8'd1, 19'd0);
        wait_done(40, cyc, rl);
        chk("op4_e", 64'(all_e), 64'h9);
        issue(2'd2, 3'd2, 4'd0, 1'b0, 1'b0, 8'd0, 19'd0);
        wait_done(40, cyc, rl);
        chk("op2_e", 64'(all_e), 64'h8);

        do_reset();
        for (int i = 0; i < 16; i++) issue(2'd1, 3'd0, 4'd0, 1'b1, 1'b0, 8'hC0, 19'(i));
        issue(2'd2, 3'd0, 4'd0, 1'b0, 1'b0, 8'd0, 19'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("abort_partial", 64'(all_e), 64'hFFE0);
        rst = 1'b1;
        #1;
        chk("abort_e", 64'(all_e), 64'h0);
        chk("abort_asid", 64'(|all_asid), 64'd0);
        chk("abort_fill", 64'(fill_index), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        #1 rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);

        for (int i = 0; i < 16; i++) issue(2'd1, 3'd0, 4'd0, 1'b1, 1'b1, 8'd3, 19'(i));
        issue(2'd2, 3'd7, 4'd0, 1'b0, 1'b0, 8'd3, 19'd0);
        wait_done(40, cyc, rl);
        chk("op7_cycles", 64'(cyc), 64'd16);
        chk("op7_e", 64'(all_e), 64'hFFFF);
        pulses = 0;
        repeat (5) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        chk("op7_single_done", 64'(pulses), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tlb_entry_writer.md
Name: tlb_entry_writer

Overview:
- Write/maintenance side of the TLB tag array: owns the E, G, ASID and VPN2 storage whose flattened contents feed the lookup-compare logic.
- Executes TLBWR (indexed write), TLBFILL (round-robin write) and INVTLB (sequential invalidate walk) requests from the pipeline's TLB-instruction stage over a valid/ready handshake.
- Lookups keep reading the outputs every cycle, including during a walk.

Parameters:
- TLBNUM, 16: number of entries. Power of two, at least 2.
- IDXW, $clog2(TLBNUM): index width. Local, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  2  0=WR, 1=FILL, 2=INV, 3=reserved (acts as NOP)
- inv_op  in  3  INVTLB sub-op 0..6
- req_index  in  IDXW  target entry for WR
- req_e  in  1  entry enable to write
- req_g  in  1  global bit to write
- req_asid  in  8  ASID to write, or INV match ASID
- req_vpn2  in  19  VPN2 to write, or INV match VPN2
- done  out  1  one-cycle pulse when a request completes
- fill_index  out  IDXW  index the next FILL will use
- all_e  out  TLBNUM  entry valid bits, entry i at bit i
- all_g  out  TLBNUM  global bits
- all_asid  out  TLBNUM*8  entry i at [8i+7:8i]
- all_vpn2  out  TLBNUM*19  entry i at [19i+18:19i]

Behaviour:
- Reset (async, rst=1):
  - all_e, all_g, all_asid, all_vpn2 = 0.
  - fill_index = 0, state = IDLE, req_ready = 1, done = 0.
  - Asserting rst mid-walk aborts the walk immediately. No done pulse is issued.
- States:
  - IDLE: req_ready=1.
  - WALK: req_ready=0.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. Request fields are sampled only at acceptance; INV fields are latched internally.
- WR: at the accept edge, entry[req_index] <= {req_e, req_g, req_asid, req_vpn2}. done=1 in the following cycle. Stays in IDLE.
- FILL: same as WR but targets entry[fill_index]. fill_index increments at that edge, wrapping from TLBNUM-1 to 0. done=1 next cycle.
- NOP (op 3): done=1 next cycle. No state change.
- INV: accept edge moves the block to WALK with walk counter k=0. In WALK, one entry is examined per cycle:
  - At each edge, entry k's E bit is cleared if match(k). Other fields are untouched.
  - k increments by 1 per edge.
  - At the edge processing k=TLBNUM-1, the block returns to IDLE and done=1 the next cycle.
  - Total: accept + TLBNUM cycles. req_ready rises in the same cycle done is high.
- match(k) by latched inv_op (a = latched ASID, v = latched VPN2):
  - 0, 1: always.
  - 2: G=1.
  - 3: G=0.
  - 4: G=0 && ASID==a.
  - 5: G=0 && ASID==a && VPN2==v.
  - 6: (G=1 || ASID==a) && VPN2==v.
  - 7: never. The walk still runs all TLBNUM cycles and done still pulses.
- Outputs are registered and reflect a write from the edge after it. A lookup during WALK sees partially invalidated state. The pipeline is responsible for stalling lookups if that matters.
- done is high for exactly one cycle per accepted request. It is never high in the cycle of acceptance.
- Entries not targeted are never modified. No out-of-range index is possible because TLBNUM is a power of two.

Decomposition:
- Shared package tlb_pkg holds:
  - TLB_OP_WR/FILL/INV/NOP constants.
  - INV_* sub-op constants 0..7.
  - Field widths ASID_W=8 and VPN2_W=19.
- One sub-module, tlb_inv_match: purely combinational; takes one entry's {g, asid, vpn2}, inv_op, a and v, and produces the hit bit.
- The top-level block holds the storage, the FSM and the counters.

Test Plan:
- Reset, then WR index 3 with e=1, g=0, asid=0x12, vpn2=0x1ABCD:
  - all_e=0x0008, all_asid[31:24]=0x12, all_vpn2[75:57]=0x1ABCD.
  - done pulses 1 cycle after accept.
- 17 back-to-back FILLs with e=1 and asid=N (N=0..16):
  - fill_index goes 0..15 then wraps to 0 and then 1.
  - Entry 0 finally holds asid=16; all_e=0xFFFF.
- Fill all entries, even entries g=1, odd entries g=0 with asid=5; then INV op 3:
  - req_ready=0 for 16 cycles; all_e=0x5555 at done.
  - A req_valid held during WALK is not accepted until done.
- Entries 2 (g=0, asid=7, vpn2=0x100), 4 (g=1, vpn2=0x100) and 6 (g=0, asid=8, vpn2=0x100); INV op 6 with a=7, v=0x100:
  - Entries 2 and 4 cleared; entry 6 stays valid.
- Assert rst at walk cycle 5 of an INV op 0 (all entries valid beforehand):
  - All outputs zero, no done pulse, req_ready=1 immediately.
- INV op 7 on a full TLB:
  - all_e unchanged after 16 walk cycles; done pulses once.
